column_group_peri_arb: RTL and testbench

Parametrised peripheral node that collects end-of-column hit words from N_COL double-columns and arbitrates them into one shared FIFO. The FIFO is drained by the downstream periphery readout arbiter. The block also drives the shared timestamp bus to all columns and adds congestion signalling. It replaces the fixed two-column node, and sits between the column super-pixel chains and the chip-level readout arbiter.

---
 rtl/peri_pkg.sv | 25 ++
 rtl/peri_sync_fifo.sv | 66 ++++++
 rtl/column_group_peri_arb.sv | 128 ++++++++++++
 tb/tb_column_group_peri_arb.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/peri_pkg.sv
// Shared definitions for the column-group periphery node: default widths,
// index-width helper and the field layout of the stored FIFO word.
package peri_pkg;

    localparam int unsigned DATA_W_DEF = 26;
    localparam int unsigned TS_W_DEF   = 9;

    // Stored word is {addr, col_idx, data}; data sits at the bottom.
    localparam int unsigned DATA_LSB = 0;

    // Index width that never collapses to zero for tiny column counts.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned idx_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned data_w,
                                             input int unsigned idx_w);
        return data_w + idx_w;
    endfunction

endpackage

// File: rtl/peri_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Push and pop are qualified
// internally so a pop on empty is ignored and a push on full only lands
// when a pop frees the slot in the same cycle.
module peri_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_40MHz,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_fill
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_fill;

    logic w_pop;
    logic w_push;

    assign o_empty = (r_fill == '0);
    assign o_full  = (r_fill == (PTR_W + 1)'(DEPTH));
    assign o_fill  = r_fill;
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    // Head is shown directly; zero while empty so stale entries never leak.
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fill <= r_fill + 1'b1;
            end else if (w_pop && !w_push) begin
                r_fill <= r_fill - 1'b1;
            end
        end
    end

    // Storage array; contents are logically cleared by the pointer reset.
    always_ff @(posedge clk_40MHz) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/column_group_peri_arb.sv
// Column-group periphery node: round-robin arbitration of N_COL
// end-of-column words into one shared FWFT FIFO, plus the shared timestamp
// bus and a congestion flag for upstream throttling.
module column_group_peri_arb
    import peri_pkg::*;
#(
    parameter int unsigned N_COL      = 4,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned TS_W       = TS_W_DEF,
    parameter int unsigned ADDR_W     = 1,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_THRESH  = 6
) (
    input  logic                                          clk_40MHz,
    input  logic                                          rst_n,
    input  logic [N_COL*DATA_W-1:0]                       i_col_data,
    input  logic [N_COL-1:0]                              i_col_valid,
    input  logic                                          i_push_flag,
    input  logic [ADDR_W-1:0]                             i_addr_config,
    input  logic                                          i_shakehands_next,
    output logic [N_COL-1:0]                              o_col_ack,
    output logic [TS_W-1:0]                               o_timestamp,
    output logic [ADDR_W+clog2_min1(N_COL)+DATA_W-1:0]    o_fifo_data,
    output logic                                          o_empty,
    output logic                                          o_full,
    output logic                                          o_congested,
    output logic [$clog2(FIFO_DEPTH):0]                   o_fill
);

    localparam int unsigned IDX_W    = clog2_min1(N_COL);
    localparam int unsigned OUT_W    = ADDR_W + IDX_W + DATA_W;
    localparam int unsigned FILL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_LSB  = idx_lsb(DATA_W);
    localparam int unsigned ADDR_LSB = addr_lsb(DATA_W, IDX_W);

    logic [TS_W-1:0]   r_timestamp;
    logic [IDX_W-1:0]  r_rr_ptr;

    logic [DATA_W-1:0] w_col_word [N_COL];
    logic              w_found;
    logic [IDX_W-1:0]  w_cand;
    logic [DATA_W-1:0] w_cand_data;
    logic [IDX_W:0]    w_scan_sum;
    logic [IDX_W-1:0]  w_rr_next;
    logic              w_pop;
    logic              w_space;
    logic              w_grant;
    logic [OUT_W-1:0]  w_wdata;

    // Split the flat column bus into per-column words.
    for (genvar g = 0; g < N_COL; g++) begin : g_col_split
        assign w_col_word[g] = i_col_data[g*DATA_W +: DATA_W];
    end

    // Round-robin scan: first valid column at or above rr_ptr, modulo N_COL.
    always_comb begin
        w_found     = 1'b0;
        w_cand      = '0;
        w_cand_data = '0;
        w_scan_sum  = '0;
        for (int k = 0; k < int'(N_COL); k++) begin
            w_scan_sum = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
            if (w_scan_sum >= (IDX_W + 1)'(N_COL)) begin
                w_scan_sum = w_scan_sum - (IDX_W + 1)'(N_COL);
            end
            if (!w_found && i_col_valid[w_scan_sum[IDX_W-1:0]]) begin
                w_found     = 1'b1;
                w_cand      = w_scan_sum[IDX_W-1:0];
                w_cand_data = w_col_word[w_scan_sum[IDX_W-1:0]];
            end
        end
    end

    // A full FIFO still accepts a word when the same cycle pops one.
    assign w_pop     = i_shakehands_next & ~o_empty;
    assign w_space   = ~o_full | w_pop;
    assign w_grant   = i_push_flag & w_found & w_space;
    assign w_rr_next = (w_cand == IDX_W'(N_COL - 1)) ? '0 : w_cand + 1'b1;

    // One-hot handshake back to the granted column.
    always_comb begin
        o_col_ack = '0;
        if (w_grant) begin
            o_col_ack[w_cand] = 1'b1;
        end
    end

    // Assemble the stored word {addr, col_idx, data}.
    always_comb begin
        w_wdata                              = '0;
        w_wdata[DATA_LSB +: DATA_W]          = w_cand_data;
        w_wdata[IDX_LSB +: IDX_W]            = w_cand;
        w_wdata[ADDR_LSB +: ADDR_W]          = i_addr_config;
    end

    // Free-running timestamp and the round-robin pointer, which moves only on a grant.
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_timestamp <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_timestamp <= r_timestamp + 1'b1;
            if (w_grant) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign o_timestamp = r_timestamp;

    peri_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_40MHz (clk_40MHz),
        .rst_n     (rst_n),
        .i_push    (w_grant),
        .i_pop     (i_shakehands_next),
        .i_wdata   (w_wdata),
        .o_rdata   (o_fifo_data),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_fill    (o_fill)
    );

    assign o_congested = (o_fill >= FILL_W'(AF_THRESH));

endmodule

// File: tb/tb_column_group_peri_arb.sv
// Scoreboard bench for column_group_peri_arb with default parameters.
// A negedge monitor predicts grants, pushes expected words into a queue and
// compares every output against that reference each cycle.
`timescale 1ns/1ps
module tb_column_group_peri_arb;

    localparam int N_COL  = 4;
    localparam int DATA_W = 26;
    localparam int TS_W   = 9;
    localparam int ADDR_W = 1;
    localparam int DEPTH  = 8;
    localparam int AF     = 6;
    localparam int IDX_W  = 2;
    localparam int OUT_W  = ADDR_W + IDX_W + DATA_W;

    logic                    clk_40MHz = 1'b0;
    logic                    rst_n     = 1'b0;
    logic [N_COL*DATA_W-1:0] col_data  = '0;
    logic [N_COL-1:0]        col_valid = '0;
    logic                    push_flag = 1'b0;
    logic [ADDR_W-1:0]       addr_cfg  = '0;
    logic                    shk       = 1'b0;

    logic [N_COL-1:0]        col_ack;
    logic [TS_W-1:0]         timestamp;
    logic [OUT_W-1:0]        fifo_data;
    logic                    empty;
    logic                    full;
    logic                    congested;
    logic [3:0]              fill;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [OUT_W-1:0] q_exp[$];
    int               m_rr = 0;
    logic [TS_W-1:0]  m_ts = '0;

    column_group_peri_arb #(
        .N_COL      (N_COL),
        .DATA_W     (DATA_W),
        .TS_W       (TS_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH),
        .AF_THRESH  (AF)
    ) dut (
        .clk_40MHz         (clk_40MHz),
        .rst_n             (rst_n),
        .i_col_data        (col_data),
        .i_col_valid       (col_valid),
        .i_push_flag       (push_flag),
        .i_addr_config     (addr_cfg),
        .i_shakehands_next (shk),
        .o_col_ack         (col_ack),
        .o_timestamp       (timestamp),
        .o_fifo_data       (fifo_data),
        .o_empty           (empty),
        .o_full            (full),
        .o_congested       (congested),
        .o_fill            (fill)
    );

    always #12 clk_40MHz = ~clk_40MHz;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor/scoreboard: compare at negedge, then advance the model for the next posedge.
    always @(negedge clk_40MHz) begin
        logic [N_COL-1:0] exp_ack;
        logic [OUT_W-1:0] head;
        logic [OUT_W-1:0] word;
        int               cand;
        int               idx;
        bit               found;
        bit               pop;
        bit               space;
        if (!rst_n) begin
            q_exp.delete();
            m_rr = 0;
            m_ts = '0;
        end
        pop   = shk && (q_exp.size() > 0);
        space = (q_exp.size() < DEPTH) || pop;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N_COL; k++) begin
            idx = (m_rr + k) % N_COL;
            if (!found && col_valid[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
        exp_ack = '0;
        if (push_flag && found && space) exp_ack[cand] = 1'b1;
        head = (q_exp.size() > 0) ? q_exp[0] : '0;

        chk("col_ack",   64'(col_ack),   64'(exp_ack));
        chk("fifo_data", 64'(fifo_data), 64'(head));
        chk("empty",     64'(empty),     64'(q_exp.size() == 0));
        chk("full",      64'(full),      64'(q_exp.size() == DEPTH));
        chk("fill",      64'(fill),      64'(q_exp.size()));
        chk("congested", 64'(congested), 64'(q_exp.size() >= AF));
        chk("timestamp", 64'(timestamp), 64'(m_ts));

        if (rst_n) begin
            if (pop) void'(q_exp.pop_front());
            if (exp_ack != '0) begin
                word = {addr_cfg, IDX_W'(cand), col_data[cand*DATA_W +: DATA_W]};
                q_exp.push_back(word);
                m_rr = (cand + 1) % N_COL;
            end
            m_ts = m_ts + 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_40MHz);
        #1;
    endtask

    task automatic idle_inputs();
        col_valid = '0;
        push_flag = 1'b0;
        shk       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        col_valid = '0;
        shk       = 1'b1;
        tick(DEPTH + 2);
        shk       = 1'b0;
    endtask

    initial begin
        col_data = {26'h3C0FFEE, 26'h2BEEF02, 26'h1DEAD01, 26'h0123400};
        addr_cfg = 1'b0;
        tick(2);
        // Reset state, held inputs idle.
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_fdata", 64'(fifo_data), 64'd0);
        chk("rst_ack",   64'(col_ack), 64'd0);
        chk("rst_ts",    64'(timestamp), 64'd0);
        rst_n = 1'b1;

        // Idle long enough to see the timestamp wrap (model checks each cycle).
        tick(520);

        // push_flag low blocks all grants.
        col_valid = 4'hF;
        tick(5);
        chk("noflag_fill", 64'(fill), 64'd0);
        chk("noflag_ack",  64'(col_ack), 64'd0);
        push_flag = 1'b1;
        #1;
        chk("first_grant_col0", 64'(col_ack), 64'h1);
        tick(1);
        idle_inputs();
        drain();

        // Single request from column 2 with node address 1.
        addr_cfg  = 1'b1;
        col_data[2*DATA_W +: DATA_W] = 26'h0ABCDEF;
        col_valid = 4'b0100;
        push_flag = 1'b1;
        #1;
        chk("single_ack", 64'(col_ack), 64'h4);
        tick(1);
        col_valid = '0;
        #1;
        chk("single_data",  64'(fifo_data), 64'({1'b1, 2'd2, 26'h0ABCDEF}));
        chk("single_empty", 64'(empty), 64'd0);
        chk("single_ack_drop", 64'(col_ack), 64'd0);
        drain();

        // All columns requesting, no reads: grants 0,1,2,3,0,1,2,3 then stall on full.
        do_reset();
        col_valid = 4'hF;
        push_flag = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("rr_order", 64'(col_ack), 64'(1 << (c % N_COL)));
            tick(1);
        end
        chk("full_flag", 64'(full), 64'd1);
        chk("full_fill", 64'(fill), 64'd8);
        tick(3);
        chk("full_noack", 64'(col_ack), 64'd0);

        // Full FIFO, read and write every cycle; fill must hold at 8.
        shk = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk("stream_fill", 64'(fill), 64'd8);
        end
        shk = 1'b0;
        drain();

        // Random traffic.
        for (int c = 0; c < 300; c++) begin
            col_valid = 4'($urandom);
            push_flag = ($urandom_range(0, 3) != 0);
            shk       = ($urandom_range(0, 2) != 0);
            addr_cfg  = 1'($urandom);
            col_data  = {$urandom, $urandom, $urandom, $urandom};
            tick(1);
        end
        drain();

        // Fill to 5, then assert reset mid-cycle.
        col_valid = 4'hF;
        push_flag = 1'b1;
        tick(5);
        idle_inputs();
        #1;
        chk("pre_rst_fill", 64'(fill), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_empty", 64'(empty), 64'd1);
        chk("async_fill",  64'(fill), 64'd0);
        chk("async_ts",    64'(timestamp), 64'd0);
        chk("async_fdata", 64'(fifo_data), 64'd0);
        tick(2);
        rst_n = 1'b1;
        col_valid = 4'hF;
        push_flag = 1'b1;
        #1;
        chk("post_rst_grant", 64'(col_ack), 64'h1);
        tick(4);
        idle_inputs();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
